// File: rtl/uart_rx_if.sv
// Host-side bus of the UART receiver: serial line in, received byte and status out.
interface uart_rx_if;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       overrun;

  // Host / line driver side
  modport master (
    output rx,
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frm_err,
    input  overrun
  );

  // Receiver side
  modport slave (
    input  rx,
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frm_err,
    output overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, start-bit qualification at
// half a bit, mid-bit data sampling, stop-bit check with framing/overrun flags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | line high, waiting for a falling edge on rx_s
// START   | half-bit wait, then re-check the start bit (glitch filter)
// DATA    | sampling 8 data bits, LSB first, one per bit period
// STOP    | sampling the stop bit; good stop publishes the byte
// WAIT_HI | stop bit was low; hold off until the line returns high
module uart_rx #(
  parameter int BAUD_CNT = 2604
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int          HALF_CNT = BAUD_CNT / 2;
  localparam logic [11:0] BAUD_TC  = 12'(BAUD_CNT - 1);
  localparam logic [11:0] HALF_TC  = 12'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        frm_q, frm_d;
  logic        ovr_q, ovr_d;

  logic        rx_s;
  logic        sample;
  logic        good_stop;
  logic        bad_stop;

  assign rx_s = sync2_q;

  // Sample strobes: start bit at half period, data/stop at full period.
  assign sample = ((state_q == START) && (baud_q == HALF_TC)) ||
                  (((state_q == DATA) || (state_q == STOP)) && (baud_q == BAUD_TC));
  assign good_stop = (state_q == STOP) && sample && rx_s;
  assign bad_stop  = (state_q == STOP) && sample && !rx_s;

  // State, synchronizer and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      baud_q  <= 12'd0;
      bit_q   <= 4'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      frm_q   <= frm_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state decision from the synchronized line and sample strobes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (sample) state_d = rx_s ? IDLE : DATA;
      DATA:    if (sample && (bit_q == 4'd7)) state_d = STOP;
      STOP:    if (sample) state_d = rx_s ? IDLE : WAIT_HI;
      WAIT_HI: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift register and host-visible status.
  always_comb begin
    baud_d  = baud_q + 12'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    frm_d   = frm_q;
    ovr_d   = ovr_q;

    // Every state change and every sample restarts the bit-period timer.
    if ((state_d != state_q) || sample) baud_d = 12'd0;

    if ((state_q == START) && (state_d == DATA)) bit_d = 4'd0;

    if ((state_q == DATA) && sample) begin
      shift_d = {rx_s, shift_q[7:1]};
      bit_d   = bit_q + 4'd1;
    end

    if (bus.clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    // A completing byte wins over a simultaneous clear; the clear consumes
    // the old byte, so overrun only flags when nobody took it.
    if (good_stop) begin
      data_d = shift_q;
      rdy_d  = 1'b1;
      frm_d  = 1'b0;
      if (rdy_q && !bus.clr_rdy) ovr_d = 1'b1;
    end

    if (bad_stop) frm_d = 1'b1;
  end

  assign bus.rx_data = data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx with a frame-level reference model.
module tb_uart_rx;
  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
  // Edge (counted from the edge before rx falls) at which the stop bit is
  // sampled: 2 sync clocks + 1 edge to enter START + half bit + 9 bit periods.
  localparam int STOP_EDGE = 3 + HALF + 9 * BAUD;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model state: what the host should see after each frame.
  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_frm;
  logic       m_ovr;

  uart_rx_if bus_if ();

  uart_rx #(.BAUD_CNT(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"}, bus_if.rx_data, m_data);
    check({tag, "_rdy"}, {7'd0, bus_if.rdy}, {7'd0, m_rdy});
    check({tag, "_frm"}, {7'd0, bus_if.frm_err}, {7'd0, m_frm});
    check({tag, "_ovr"}, {7'd0, bus_if.overrun}, {7'd0, m_ovr});
  endtask

  // Frame-level effect of one received frame on the host view.
  task automatic model_frame(input logic [7:0] b, input logic stop_b, input logic clr_same);
    if (stop_b) begin
      if (m_rdy && !clr_same) m_ovr = 1'b1;
      else if (clr_same)      m_ovr = 1'b0;
      m_data = b;
      m_rdy  = 1'b1;
      m_frm  = 1'b0;
    end else begin
      m_frm = 1'b1;
    end
  endtask

  // Drive one 8N1 frame; clr_edge pulses clr_rdy at that edge, abort_edge
  // stops driving just before that edge (0 disables either).
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input int clr_edge, input int abort_edge);
    logic [9:0] bits;
    bits = {stop_b, b, 1'b0};
    @(posedge clk);
    #1;
    for (int k = 1; k <= 10 * BAUD; k++) begin
      if (abort_edge != 0 && k == abort_edge) return;
      bus_if.rx      = bits[(k - 1) / BAUD];
      bus_if.clr_rdy = (k == clr_edge);
      @(posedge clk);
      #1;
    end
    bus_if.clr_rdy = 1'b0;
  endtask

  task automatic pulse_clr();
    bus_if.clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus_if.clr_rdy = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    bus_if.rx = 1'b1;
    repeat (n * BAUD) @(posedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    logic       good;
    checks = 0;
    errors = 0;
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_frm  = 1'b0;
    m_ovr  = 1'b0;
    rst            = 1'b1;
    bus_if.rx      = 1'b1;
    bus_if.clr_rdy = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bits(1);

    // Single byte, held until cleared.
    send_frame(8'hA5, 1'b1, 0, 0);
    model_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    check_all("a5");
    idle_bits(3);
    @(negedge clk);
    check_all("a5_hold");
    pulse_clr();
    check_all("a5_clr");

    // Glitch rejection then a good frame.
    @(posedge clk);
    #1;
    bus_if.rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_if.rx = 1'b1;
    repeat (2 * BAUD) @(posedge clk);
    @(negedge clk);
    check_all("glitch");
    send_frame(8'h3C, 1'b1, 0, 0);
    model_frame(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check_all("3c");
    pulse_clr();

    // Framing error with the line held low, then recovery.
    send_frame(8'h55, 1'b0, 0, 0);
    model_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_all("frm_low");
    idle_bits(1);
    @(negedge clk);
    check_all("frm_release");
    send_frame(8'h0F, 1'b1, 0, 0);
    model_frame(8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    check_all("0f");
    pulse_clr();

    // Overrun from back-to-back frames, cleared by one pulse.
    send_frame(8'h11, 1'b1, 0, 0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 0, 0);
    model_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    check_all("ovr");
    pulse_clr();
    check_all("ovr_clr");

    // Clear coinciding with the completing byte: set wins, no overrun.
    send_frame(8'h11, 1'b1, 0, 0);
    model_frame(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    check_all("sim_first");
    send_frame(8'h22, 1'b1, STOP_EDGE, 0);
    model_frame(8'h22, 1'b1, 1'b1);
    @(negedge clk);
    check_all("sim_clr");
    pulse_clr();

    // Randomized frames against the model.
    for (int i = 0; i < 12; i++) begin
      rb   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) pulse_clr();
      send_frame(rb, good, 0, 0);
      model_frame(rb, good, 1'b0);
      if (!good) begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_all($sformatf("rnd%0d_bad", i));
        idle_bits(1);
      end
      @(negedge clk);
      check_all($sformatf("rnd%0d", i));
    end

    // Reset during bit 4 of 0xFF, then a clean frame.
    send_frame(8'hFF, 1'b1, 0, 5 * BAUD + 8);
    #2;
    rst = 1'b1;
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_frm  = 1'b0;
    m_ovr  = 1'b0;
    #1;
    check_all("async_rst");
    bus_if.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bits(1);
    @(negedge clk);
    check_all("post_rst");
    send_frame(8'h81, 1'b1, 0, 0);
    model_frame(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    check_all("81");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the team's UART transmitter and uses the same bit period: 2604 clocks per bit.
- It synchronizes the asynchronous serial line and detects the start bit. It samples each bit at mid-period and delivers the received byte with a ready flag.
- A host-side consumer clears the ready flag.
- The block also flags framing errors and overruns.

Parameters:
- BAUD_CNT, 2604, clocks per bit period (counter terminal count is BAUD_CNT-1).
- HALF_CNT, BAUD_CNT/2 (1302), clocks from start-edge detect to the start-bit mid-sample.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- clr_rdy  input  1  single-cycle pulse that clears rdy and overrun.
- rx_data  output  8  last correctly framed byte, LSB received first.
- rdy  output  1  a byte is available in rx_data; held until cleared.
- frm_err  output  1  the last frame had a low stop bit; cleared by the next good frame.
- overrun  output  1  a byte completed while rdy was already 1; sticky.

Behaviour:
- Reset: rst is asynchronous and active-high.
  - Outputs: rx_data=8'h00, rdy=0, frm_err=0, overrun=0.
  - Internal: both synchronizer flops = 1, state=IDLE, baud counter=0, bit counter=0, shift register=8'h00.
- Synchronizer: rx passes through two flops to give rx_s. All decisions use rx_s only; raw rx is never used. Synchronizer latency is 2 clocks.
- Counters:
  - Baud counter is 12 bits. It is cleared on every state entry and whenever a sample is taken; otherwise it increments by 1.
  - Bit counter is 4 bits, counts 0..8, and is cleared on DATA entry.
- State machine (states IDLE, START, DATA, STOP, WAIT_HI):
  - IDLE: rx_s==0 -> START, baud counter cleared.
  - START: when baud counter == HALF_CNT-1, sample rx_s.
    - If 1 (glitch): -> IDLE. No flags change.
    - If 0: -> DATA.
  - DATA: when baud counter == BAUD_CNT-1, sample rx_s.
    - The sample shifts into the MSB of the shift register (right shift), so after 8 samples bit0 is the first received bit.
    - The bit counter increments on each sample; after the 8th sample -> STOP.
  - STOP: when baud counter == BAUD_CNT-1, sample rx_s.
    - If 1: rx_data <= shift register, rdy <= 1, frm_err <= 0. If rdy was already 1, also overrun <= 1 (rx_data is overwritten). -> IDLE.
    - If 0: frm_err <= 1; rx_data, rdy and overrun are unchanged. -> WAIT_HI.
  - WAIT_HI: stays here until rx_s==1, then -> IDLE. This prevents a break or stuck-low line from re-triggering start detection.
- Latency:
  - rdy rises 2 + HALF_CNT + 9*BAUD_CNT (±1) clocks after the falling edge on rx. This is the clock after the stop-bit mid-sample.
  - With defaults that is about 24740 clocks.
- rdy/overrun clearing:
  - clr_rdy=1 clears rdy and overrun on the next edge.
  - If clr_rdy coincides with a good-stop update, the set wins: rdy=1 and overrun=0. The old byte counts as consumed in the same cycle, so no overrun is flagged.
- clr_rdy never affects frm_err.
- Reset mid-frame: the frame is aborted immediately and all state returns to reset values. The next frame is received normally after rx idles high.
- Back-to-back frames: a start bit may begin right after the stop-bit mid-sample. Because IDLE is re-entered about 0.5 bit before the stop-bit end, the next falling edge is detected normally.
- No parity, no baud auto-detect, no FIFO.

Test Plan:
- Single byte, BAUD_CNT=16: send 8'hA5 as 8N1 -> rdy rises once, rx_data=8'hA5, frm_err=0, overrun=0. rdy stays 1 until clr_rdy pulses, then it is 0 on the next cycle.
- Glitch rejection, BAUD_CNT=16: rx low for 3 clocks, then high -> state returns to IDLE; rdy=0 and rx_data=8'h00 unchanged. A following 8'h3C frame is received correctly.
- Framing error: send 8'h55 with stop bit 0, hold rx low 40 clocks, then release.
  - Expect frm_err=1, rdy=0, rx_data unchanged, and no spurious frame while rx is low.
  - A following good 8'h0F frame gives rdy=1, rx_data=8'h0F, frm_err=0.
- Overrun: send 8'h11 then 8'h22 back-to-back without clr_rdy -> rx_data=8'h22, rdy=1, overrun=1. A clr_rdy pulse clears both rdy and overrun.
- Simultaneous clr_rdy: with rdy=1 holding 8'h11, pulse clr_rdy in the same cycle 8'h22 completes -> rdy=1, rx_data=8'h22, overrun=0.
- Reset mid-frame: assert rst during bit 4 of 8'hFF -> all outputs are 0 immediately (asynchronous). After release, 8'h81 is received correctly, with rdy=1 and rx_data=8'h81.
